fetch_unit: RTL
===============

Name: fetch_unit

Overview:
IF stage plus IF/ID pipeline register for the 5-stage RISC-V pipeline. It consumes the stall/flush controls (IF_en, IF_ID_en, is_nop_IF_ID) and the branch redirect. It drives instruction-memory requests over a req/ready handshake and presents {pc, instr, valid} to ID. Multi-cycle memory latency inserts bubbles into IF/ID; the stall controller never sees a pending fetch.

Parameters:
PC_WIDTH, 32, width of PC and memory address
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
IF_en  in  1  PC may advance
IF_ID_en  in  1  IF/ID register may load
is_nop_IF_ID  in  1  flush IF/ID to bubble
branch_taken  in  1  redirect fetch (from EXE)
branch_target  in  PC_WIDTH  redirect address; bits [1:0] forced to 0
imem_req  out  1  fetch request
imem_addr  out  PC_WIDTH  fetch address, equals pc
imem_ready  in  1  rdata valid this cycle, completes request
imem_rdata  in  32  fetched instruction
pc  out  PC_WIDTH  current fetch PC
pc_IF_ID  out  PC_WIDTH  PC of instruction in IF/ID
instr_IF_ID  out  32  instruction in IF/ID
valid_IF_ID  out  1  IF/ID holds a real instruction
fetch_busy  out  1  request outstanding, no instruction available

Behaviour:
- Reset (rst=1 at edge): state=RESET, pc=RESET_PC, pc_IF_ID=0, instr_IF_ID=NOP_INSTR, valid_IF_ID=0, hold buffer empty, imem_req=0. rst overrides every other input.
- States:
  - RESET: goes to FETCH on the next cycle.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: instruction buffered; imem_req=0.
  - DRAIN: stale request outstanding; imem_req=1 with the old address.
- Request rules: once imem_req is raised, imem_addr stays stable until imem_ready is sampled high. A request is never withdrawn early; a redirect during a request uses DRAIN.
- avail = (FETCH & imem_ready) | HOLD. The instruction is imem_rdata in FETCH and the buffer in HOLD.
- advance = avail & IF_en & IF_ID_en & !branch_taken & !is_nop_IF_ID.
- IF/ID update, one priority per cycle:
  1. If is_nop_IF_ID | branch_taken: instr_IF_ID=NOP_INSTR, valid_IF_ID=0, pc_IF_ID=0. This applies regardless of IF_ID_en.
  2. Else if advance: IF/ID={pc, instr, 1}.
  3. Else if IF_ID_en & !avail: bubble (NOP, valid 0).
  4. Else IF/ID holds its value.
- PC and state update, in priority order:
  - branch_taken:
    - pc=branch_target&~3.
    - If FETCH & !imem_ready, go to DRAIN; otherwise go to FETCH.
    - The HOLD buffer is discarded.
  - advance: pc=pc+4 (mod 2^PC_WIDTH, 0xFFFF_FFFC wraps to 0), state=FETCH. Fetch latency is one cycle minimum when imem_ready is combinational in the request cycle.
  - avail & !advance & !is_nop_IF_ID:
    - Instruction is stalled; store it in the buffer, state=HOLD, pc holds.
    - HOLD persists until advance or a redirect.
  - is_nop_IF_ID without branch: the available instruction is still retained (flush kills the IF/ID contents, not IF). Next state is HOLD if avail, otherwise unchanged.
  - DRAIN: on imem_ready, discard rdata and go to FETCH with the new pc. A further branch_taken while in DRAIN only updates pc.
- fetch_busy = (FETCH & !imem_ready) | DRAIN.
- Outputs pc, pc_IF_ID, instr_IF_ID and valid_IF_ID are registered. imem_req and fetch_busy are decoded from state and imem_ready only.
- Simultaneous cases:
  - branch_taken and imem_ready in FETCH: take the branch, drop rdata, go to FETCH, no DRAIN.
  - rst during DRAIN: go to RESET. The outstanding response is ignored because imem_req=0 in RESET.

Test Plan:
- Reset, then imem_ready held 1 and rdata=addr-derived: pc steps 0,4,8; IF/ID shows {0,I0,1} one cycle after the first request, then {4,I1,1}.
- IF_en=IF_ID_en=0 for 3 cycles with imem_ready=1 at pc=8: state HOLD, imem_req=0, pc=8, IF/ID frozen. On release, IF/ID={8,I2,1} and pc=12.
- imem_ready low for 2 cycles at pc=4: fetch_busy=1, IF/ID gets NOP/valid 0 twice. Third cycle ready: IF/ID={4,I1,1}.
- branch_taken=1, target=0x103 while a request to 0x10 is pending: state DRAIN, pc=0x100. Response for 0x10 is discarded, then imem_addr=0x100 and no stale instruction reaches IF/ID.
- is_nop_IF_ID=1 with IF_ID_en=0: IF/ID becomes NOP, valid 0. pc unchanged; the fetched instruction is delivered once the stall clears.
- pc=0xFFFF_FFFC advance: pc wraps to 0x0.

Source files
------------

// File: rtl/fetch_unit.sv
// IF stage + IF/ID register: issues imem fetches over req/ready, buffers stalled instructions, presents {pc, instr, valid} to ID.
// Latency: one cycle minimum from request to IF/ID. Backpressure: IF_en/IF_ID_en stall parks the instruction in a hold buffer.
module fetch_unit #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IF_en,
  input  logic                IF_ID_en,
  input  logic                is_nop_IF_ID,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_IF_ID,
  output logic [31:0]         instr_IF_ID,
  output logic                valid_IF_ID,
  output logic                fetch_busy
);

  typedef enum logic [1:0] {
    S_RESET,
    S_FETCH,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t              state, state_nxt;
  logic [PC_WIDTH-1:0] pc_nxt;
  logic [PC_WIDTH-1:0] drain_addr, drain_addr_nxt;
  logic [31:0]         hold_buf, hold_buf_nxt;
  logic                avail;
  logic                flush;
  logic                advance;
  logic [31:0]         fetch_instr;

  assign avail       = ((state == S_FETCH) && imem_ready) || (state == S_HOLD);
  assign fetch_instr = (state == S_HOLD) ? hold_buf : imem_rdata;
  assign flush       = is_nop_IF_ID | branch_taken;
  assign advance     = avail & IF_en & IF_ID_en & ~flush;

  assign imem_req   = (state == S_FETCH) || (state == S_DRAIN);
  // A redirected request keeps presenting its original address until it completes.
  assign imem_addr  = (state == S_DRAIN) ? drain_addr : pc;
  assign fetch_busy = ((state == S_FETCH) && !imem_ready) || (state == S_DRAIN);

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    drain_addr_nxt = drain_addr;
    hold_buf_nxt   = hold_buf;
    if (branch_taken) begin
      pc_nxt = branch_target & ~PC_WIDTH'(3);
      if (imem_req && !imem_ready) begin
        state_nxt = S_DRAIN;
        if (state == S_FETCH) begin
          drain_addr_nxt = pc;
        end
      end else begin
        state_nxt = S_FETCH;
      end
    end else if (advance) begin
      pc_nxt    = pc + PC_WIDTH'(4);
      state_nxt = S_FETCH;
    end else if (avail) begin
      // Stall or flush without redirect: keep the instruction for later delivery.
      if (state == S_FETCH) begin
        hold_buf_nxt = imem_rdata;
      end
      state_nxt = S_HOLD;
    end else begin
      case (state)
        S_RESET: state_nxt = S_FETCH;
        S_DRAIN: if (imem_ready) state_nxt = S_FETCH;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      drain_addr <= '0;
      hold_buf   <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      drain_addr <= drain_addr_nxt;
      hold_buf   <= hold_buf_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_IF_ID    <= '0;
      instr_IF_ID <= NOP_INSTR;
      valid_IF_ID <= 1'b0;
    end else if (flush) begin
      pc_IF_ID    <= '0;
      instr_IF_ID <= NOP_INSTR;
      valid_IF_ID <= 1'b0;
    end else if (advance) begin
      pc_IF_ID    <= pc;
      instr_IF_ID <= fetch_instr;
      valid_IF_ID <= 1'b1;
    end else if (IF_ID_en && !avail) begin
      pc_IF_ID    <= '0;
      instr_IF_ID <= NOP_INSTR;
      valid_IF_ID <= 1'b0;
    end
  end

endmodule
